demux1_2_reg: RTL and testbench

DEMUX1_2_REG -- requirements
Module: demux1_2_reg

---
 rtl/demux1_2_reg.sv | 119 +++++++++++
 tb/tb_demux1_2_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_reg.sv
// demux1_2_reg: routes a 32-bit word stream to one of two outputs.
// Each output has a one-entry register slot with a ready/valid handshake.
// A slot can accept a new word in the same cycle it drains, so it runs at
// full rate with no bubbles.
// Optional build macro DEMUX_XFER_CNT_EN adds a 16-bit handshake counter
// per output (out0_cnt / out1_cnt).
module demux1_2_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
`ifdef DEMUX_XFER_CNT_EN
    output logic [DATA_W-1:0] out1_data,
    output logic [CNT_W-1:0]  out0_cnt,
    output logic [CNT_W-1:0]  out1_cnt
`else
    output logic [DATA_W-1:0] out1_data
`endif
);

    // Slot state: the valid bit marks FULL, and the data register holds the last loaded word.
    logic              vld0_p1;
    logic              vld1_p1;
    logic [DATA_W-1:0] data0_p1;
    logic [DATA_W-1:0] data1_p1;

    logic              in_fire;
    logic              load0;
    logic              load1;
    logic              drain0;
    logic              drain1;

    // A selected slot is free when it is empty or its sink is taking the word this cycle.
    // There is no path from in_valid to in_ready.
    assign in_ready = rst_n && !flush &&
                      (in_sel ? (!vld1_p1 || out1_ready) : (!vld0_p1 || out0_ready));

    assign in_fire = in_valid && in_ready;
    assign load0   = in_fire && !in_sel;
    assign load1   = in_fire &&  in_sel;
    assign drain0  = vld0_p1 && out0_ready;
    assign drain1  = vld1_p1 && out1_ready;

    // ---- input -> slot stage ----
    // Slot 0 state: flush empties it, a load fills it (this also covers drain+load),
    // and a drain alone empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0_p1 <= 1'b0;
        end else if (flush) begin
            vld0_p1 <= 1'b0;
        end else if (load0) begin
            vld0_p1 <= 1'b1;
        end else if (drain0) begin
            vld0_p1 <= 1'b0;
        end
    end

    // Slot 1 state: same transitions as slot 0, independent of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_p1 <= 1'b0;
        end else if (flush) begin
            vld1_p1 <= 1'b0;
        end else if (load1) begin
            vld1_p1 <= 1'b1;
        end else if (drain1) begin
            vld1_p1 <= 1'b0;
        end
    end

    // Slot data registers: they change only on a load, so the word stays stable
    // while it waits for its sink. Reset clears them so the outputs never show X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_p1 <= '0;
            data1_p1 <= '0;
        end else begin
            if (load0) data0_p1 <= in_data;
            if (load1) data1_p1 <= in_data;
        end
    end

    assign out0_valid = vld0_p1;
    assign out1_valid = vld1_p1;
    assign out0_data  = data0_p1;
    assign out1_data  = data1_p1;

`ifdef DEMUX_XFER_CNT_EN
    logic [CNT_W-1:0] cnt0_p1;
    logic [CNT_W-1:0] cnt1_p1;

    // Output handshake counters: they wrap naturally, and flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_p1 <= '0;
            cnt1_p1 <= '0;
        end else begin
            if (drain0) cnt0_p1 <= cnt0_p1 + 1'b1;
            if (drain1) cnt1_p1 <= cnt1_p1 + 1'b1;
        end
    end

    assign out0_cnt = cnt0_p1;
    assign out1_cnt = cnt1_p1;
`endif

endmodule

// File: tb/tb_demux1_2_reg.sv
// Testbench for demux1_2_reg: directed vector table plus hand-written sequences.
module tb_demux1_2_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_data;
`ifdef DEMUX_XFER_CNT_EN
    logic [15:0] out0_cnt;
    logic [15:0] out1_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    demux1_2_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
`ifdef DEMUX_XFER_CNT_EN
        .out1_data  (out1_data),
        .out0_cnt   (out0_cnt),
        .out1_cnt   (out1_cnt)
`else
        .out1_data  (out1_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        sel;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        fl;
        logic        e_ir;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1, input logic fl);
        in_valid   = iv;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        flush      = fl;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // The table lists the state expected before each edge; the inputs are applied in that same cycle.
        //            iv  sel d              r0 r1 fl  ir  v0  d0            v1  d1
        tbl[0]  = '{1'b1,1'b0,32'hDEADBEEF,1'b0,1'b0,1'b0, 1'b1,1'b0,32'h0,       1'b0,32'h0};
        tbl[1]  = '{1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,1'b0,32'h0};
        tbl[2]  = '{1'b0,1'b1,32'h0,       1'b0,1'b0,1'b0, 1'b1,1'b1,32'hDEADBEEF,1'b0,32'h0};
        tbl[3]  = '{1'b1,1'b1,32'hA5A50001,1'b0,1'b0,1'b0, 1'b1,1'b1,32'hDEADBEEF,1'b0,32'h0};
        tbl[4]  = '{1'b1,1'b1,32'h00000BAD,1'b0,1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,1'b1,32'hA5A50001};
        tbl[5]  = '{1'b1,1'b1,32'h00000BAD,1'b1,1'b1,1'b0, 1'b1,1'b1,32'hDEADBEEF,1'b1,32'hA5A50001};
        tbl[6]  = '{1'b0,1'b0,32'h0,       1'b0,1'b1,1'b0, 1'b1,1'b0,32'hDEADBEEF,1'b1,32'h00000BAD};
        tbl[7]  = '{1'b1,1'b0,32'h00000011,1'b0,1'b0,1'b0, 1'b1,1'b0,32'hDEADBEEF,1'b0,32'h00000BAD};
        tbl[8]  = '{1'b1,1'b0,32'h00000022,1'b1,1'b0,1'b0, 1'b1,1'b1,32'h00000011,1'b0,32'h00000BAD};
        tbl[9]  = '{1'b1,1'b1,32'h00000033,1'b0,1'b0,1'b0, 1'b1,1'b1,32'h00000022,1'b0,32'h00000BAD};
        tbl[10] = '{1'b1,1'b0,32'h00000044,1'b0,1'b0,1'b1, 1'b0,1'b1,32'h00000022,1'b1,32'h00000033};
        tbl[11] = '{1'b1,1'b1,32'h00000055,1'b0,1'b0,1'b1, 1'b0,1'b0,32'h00000022,1'b0,32'h00000033};
        tbl[12] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0, 1'b1,1'b0,32'h00000022,1'b0,32'h00000033};

        // Reset state: in_ready stays low even with in_valid high.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_out0_valid", {31'h0, out0_valid}, 32'h0);
        chk("rst_out1_valid", {31'h0, out1_valid}, 32'h0);
        chk("rst_out0_data", out0_data, 32'h0);
        chk("rst_out1_data", out1_data, 32'h0);
        rst_n = 1'b1;
        #1;

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1, tbl[i].fl);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'h0, in_ready}, {31'h0, tbl[i].e_ir});
            chk($sformatf("v%0d_out0_valid", i), {31'h0, out0_valid}, {31'h0, tbl[i].e_v0});
            chk($sformatf("v%0d_out0_data", i), out0_data, tbl[i].e_d0);
            chk($sformatf("v%0d_out1_valid", i), {31'h0, out1_valid}, {31'h0, tbl[i].e_v1});
            chk($sformatf("v%0d_out1_data", i), out1_data, tbl[i].e_d1);
            tick();
        end

        // Stream 8 words to port 1 with its sink always ready: expect no bubbles and in-order data.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(1'b1, 1'b1, 32'h100 + i, 1'b0, 1'b1, 1'b0);
            else       drive(1'b0, 1'b1, 32'h0,       1'b0, 1'b1, 1'b0);
            #1;
            if (i < 8) chk($sformatf("stream_in_ready%0d", i), {31'h0, in_ready}, 32'h1);
            if (i > 0) begin
                chk($sformatf("stream_out1_valid%0d", i), {31'h0, out1_valid}, 32'h1);
                chk($sformatf("stream_out1_data%0d", i), out1_data, 32'h100 + i - 1);
            end
            chk($sformatf("stream_out0_valid%0d", i), {31'h0, out0_valid}, 32'h0);
            tick();
        end
        chk("stream_drained", {31'h0, out1_valid}, 32'h0);

        // Asynchronous reset asserted mid-cycle while both slots are full.
        drive(1'b1, 1'b0, 32'hCAFE0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("async_pre_v0", {31'h0, out0_valid}, 32'h1);
        chk("async_pre_v1", {31'h0, out1_valid}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_v0", {31'h0, out0_valid}, 32'h0);
        chk("async_v1", {31'h0, out1_valid}, 32'h0);
        chk("async_d0", out0_data, 32'h0);
        chk("async_d1", out1_data, 32'h0);
        chk("async_in_ready", {31'h0, in_ready}, 32'h0);
        tick();
        rst_n = 1'b1;
        // First accept is possible in the first cycle after deassertion.
        drive(1'b1, 1'b0, 32'h0000BEEF, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst_v0", {31'h0, out0_valid}, 32'h1);
        chk("post_rst_d0", out0_data, 32'h0000BEEF);
        chk("post_rst_v1", {31'h0, out1_valid}, 32'h0);

`ifdef DEMUX_XFER_CNT_EN
        // 65537 handshakes on port 0: the counter wraps to 1.
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 1'b0, i, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("cnt0_wrap", {16'h0, out0_cnt}, 32'h1);
        chk("cnt1_idle", {16'h0, out1_cnt}, 32'h0);
        // A flush does not clear the counters.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("cnt0_after_flush", {16'h0, out0_cnt}, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
